game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter SCORE_W, default 8, sets the score counter width in bits.
REQ-002 Parameter N_AST, default 20, sets the number of per-asteroid hit inputs.
REQ-003 Parameter LIVES_INIT, default 3, sets lives loaded at game start (1..2^LIVES_W-1).
REQ-004 Parameter LIVES_W, default 2, sets the lives counter width.
REQ-005 Parameter POINTS, default 1, sets score added per destroyed asteroid.
REQ-006 Parameter INVULN_FRAMES, default 120, sets frames spent in DYING.
REQ-007 Parameter OVER_FRAMES, default 180, sets frames spent in OVER.
REQ-008 Parameter LEVEL_W, default 4, sets the level counter width.
REQ-009 clk  input  1  100 MHz system clock; all logic on rising edge.
REQ-010 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-011 pixpulse  input  1  pixel-rate enable, 1 clk in every 4; every state update is qualified by it.
REQ-012 vblank  input  1  vertical blank from the VGA timing generator.
REQ-013 shoot  input  1  fire button, level-sensitive; also serves as start.
REQ-014 ast_hit  input  N_AST  per-asteroid destroyed pulses, any number may be set at once.
REQ-015 ship_hit  input  1  ship collision pulse.
REQ-016 all_broken  input  1  wave-cleared pulse.
REQ-017 game_state  output  2  IDLE=0, PLAY=1, DYING=2, OVER=3.
REQ-018 score  output  SCORE_W  current score.
REQ-019 lives  output  LIVES_W  remaining lives.
REQ-020 level  output  LEVEL_W  current wave number.
REQ-021 move  output  1  one-clk frame strobe.
REQ-022 ship_en  output  1  high when the ship may be drawn and moved.
REQ-023 wave_next  output  1  one-clk pulse requesting the next asteroid wave.

Function
REQ-024 An internal vblank_d register and shoot_d register shall update only on pixpulse cycles.
REQ-025 move shall be 1 for exactly the clk cycle where pixpulse=1, vblank=1, vblank_d=0; the input and output samples are registered, so move rises 1 clk after that sample.
REQ-026 A start event shall be pixpulse=1, shoot=1, shoot_d=0.
REQ-027 IDLE: on start -> PLAY; score<=0, lives<=LIVES_INIT, level<=1; score is otherwise held, showing the last game's result.
REQ-028 PLAY and DYING: on each pixpulse, score shall add POINTS*popcount(ast_hit), saturating at 2^SCORE_W-1 with no wrap.
REQ-029 PLAY: ship_hit with lives>1 -> lives-1, frame counter<=INVULN_FRAMES, go to DYING.
REQ-030 PLAY: ship_hit with lives==1 -> lives<=0, frame counter<=OVER_FRAMES, go to OVER.
REQ-031 DYING: ship_hit shall be ignored; the counter shall decrement on each move strobe; at 0 -> PLAY.
REQ-032 OVER: the counter shall decrement on each move strobe; at 0 -> IDLE; shoot, ast_hit, and ship_hit shall be ignored.
REQ-033 all_broken in PLAY or DYING shall increment level, saturating at 2^LEVEL_W-1, and pulse wave_next for one clk.
REQ-034 all_broken in IDLE or OVER shall be ignored.
REQ-035 When ship_hit and ast_hit occur on the same pixpulse, both the score addition and the life loss shall apply.
REQ-036 When all_broken and ship_hit occur on the same pixpulse, the level increment and the state change shall both apply.
REQ-037 ship_en shall be 1 in PLAY; in DYING it shall follow counter bit 3, blinking; in IDLE and OVER it shall be 0.
REQ-038 All outputs shall be registered; no combinational path from inputs to outputs is permitted.

Reset
REQ-039 rst=1 at any clk edge, including mid-game or mid-countdown, shall force the following: game_state=IDLE, score=0, lives=LIVES_INIT, level=0, move=0, ship_en=0, wave_next=0, counter=0, vblank_d=0, shoot_d=0.
REQ-040 rst shall take priority over every other input in the same cycle.

Verification
REQ-041 Reset, hold shoot=1 from reset release -> no start until shoot goes 0 then 1; then game_state=1, lives=3, level=1, score=0.
REQ-042 PLAY, ast_hit=20'h0000F on one pixpulse with POINTS=1 -> score +4; with score=254, the same stimulus -> score=255, then stays 255.
REQ-043 PLAY, lives=3, ship_hit -> lives=2, game_state=2, ship_en blinks; ship_hit during DYING -> lives unchanged; after 120 vblank rises -> game_state=1.
REQ-044 PLAY, lives=1, ship_hit together with ast_hit bit0 -> score+1, lives=0, game_state=3; after 180 frames -> game_state=0, score retained.
REQ-045 all_broken in PLAY at level=15 (LEVEL_W=4) -> level stays 15 and wave_next pulses one clk; all_broken in IDLE -> no pulse.
REQ-046 rst asserted during OVER countdown -> next clk: game_state=0, score=0, lives=3, move=0.

Source files
------------

// File: rtl/game_ctrl.sv
// GameCtrl: top-level game state machine for the asteroids game.
// Tracks the game phase, score, lives and wave number, and derives the
// per-frame move strobe, ship enable and next-wave request.
// All state advances only on pixel-enable cycles. Every output comes straight from a register.
module game_ctrl #(
    parameter int SCORE_W       = 8,
    parameter int N_AST         = 20,
    parameter int LIVES_INIT    = 3,
    parameter int LIVES_W       = 2,
    parameter int POINTS        = 1,
    parameter int INVULN_FRAMES = 120,
    parameter int OVER_FRAMES   = 180,
    parameter int LEVEL_W       = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pixpulse_i,
    input  logic               vblank_i,
    input  logic               shoot_i,
    input  logic [N_AST-1:0]   ast_hit_i,
    input  logic               ship_hit_i,
    input  logic               all_broken_i,
    output logic [1:0]         game_state_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [LIVES_W-1:0] lives_o,
    output logic [LEVEL_W-1:0] level_o,
    output logic               move_o,
    output logic               ship_en_o,
    output logic               wave_next_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } stateT;

    localparam int MAX_FRAMES = (INVULN_FRAMES > OVER_FRAMES) ? INVULN_FRAMES : OVER_FRAMES;
    localparam int CNT_RAW    = $clog2(MAX_FRAMES + 1);
    // The ship blink in DYING uses counter bit 3, so the counter is never narrower than 4 bits.
    localparam int CNT_W      = (CNT_RAW < 4) ? 4 : CNT_RAW;
    localparam int HC_W       = $clog2(N_AST + 1);
    localparam int SUM_W      = SCORE_W + 32;

    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};
    localparam logic [SUM_W-1:0]   SUM_MAX   = SUM_W'(SCORE_MAX);

    stateT               state_q, state_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [LIVES_W-1:0]  lives_q, lives_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]    frameCnt_q, frameCnt_d;
    logic                shipEn_q, shipEn_d;
    logic                waveNext_q, waveNext_d;
    logic                move_q;
    logic                vblankPrev_q;
    logic                shootPrev_q;
    logic                shootArmed_q;

    logic                frameTick;
    logic                startEvt;
    logic [HC_W-1:0]     hitCount;
    logic [SUM_W-1:0]    scoreSum;
    logic [SCORE_W-1:0]  scoreSat;
    logic [LEVEL_W-1:0]  levelInc;

    // Frame and start edge detection.
    // A start needs fire to have been seen released since reset, so holding fire through reset does not launch a game.
    always_comb begin
        frameTick = pixpulse_i & vblank_i & ~vblankPrev_q;
        startEvt  = pixpulse_i & shoot_i & ~shootPrev_q & shootArmed_q;
    end

    // Count destroyed asteroids this cycle and form the saturated score and level candidates.
    always_comb begin
        hitCount = '0;
        for (int i = 0; i < N_AST; i++) begin
            hitCount = hitCount + HC_W'(ast_hit_i[i]);
        end
        scoreSum = SUM_W'(score_q) + SUM_W'(hitCount) * SUM_W'(POINTS);
        scoreSat = (scoreSum > SUM_MAX) ? SCORE_MAX : scoreSum[SCORE_W-1:0];
        levelInc = (level_q == LEVEL_MAX) ? level_q : level_q + 1'b1;
    end

    // Next-state logic for the game phase, counters and output strobes.
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        lives_d    = lives_q;
        level_d    = level_q;
        frameCnt_d = frameCnt_q;
        waveNext_d = 1'b0;
        if (pixpulse_i) begin
            case (state_q)
                IDLE: begin
                    if (startEvt) begin
                        state_d    = PLAY;
                        score_d    = '0;
                        lives_d    = LIVES_W'(LIVES_INIT);
                        level_d    = LEVEL_W'(1);
                        frameCnt_d = '0;
                    end
                end
                PLAY: begin
                    score_d = scoreSat;
                    if (all_broken_i) begin
                        level_d    = levelInc;
                        waveNext_d = 1'b1;
                    end
                    if (ship_hit_i) begin
                        if (lives_q > LIVES_W'(1)) begin
                            lives_d    = lives_q - 1'b1;
                            frameCnt_d = CNT_W'(INVULN_FRAMES);
                            state_d    = DYING;
                        end else begin
                            lives_d    = '0;
                            frameCnt_d = CNT_W'(OVER_FRAMES);
                            state_d    = OVER;
                        end
                    end
                end
                DYING: begin
                    score_d = scoreSat;
                    if (all_broken_i) begin
                        level_d    = levelInc;
                        waveNext_d = 1'b1;
                    end
                    if (frameCnt_q == '0) begin
                        state_d = PLAY;
                    end else if (frameTick) begin
                        frameCnt_d = frameCnt_q - 1'b1;
                    end
                end
                OVER: begin
                    if (frameCnt_q == '0) begin
                        state_d = IDLE;
                    end else if (frameTick) begin
                        frameCnt_d = frameCnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        shipEn_d = (state_d == PLAY) | ((state_d == DYING) & frameCnt_d[3]);
    end

    // Register all state and outputs; synchronous reset overrides everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            score_q      <= '0;
            lives_q      <= LIVES_W'(LIVES_INIT);
            level_q      <= '0;
            frameCnt_q   <= '0;
            shipEn_q     <= 1'b0;
            waveNext_q   <= 1'b0;
            move_q       <= 1'b0;
            vblankPrev_q <= 1'b0;
            shootPrev_q  <= 1'b0;
            shootArmed_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            frameCnt_q <= frameCnt_d;
            shipEn_q   <= shipEn_d;
            waveNext_q <= waveNext_d;
            move_q     <= frameTick;
            if (pixpulse_i) begin
                vblankPrev_q <= vblank_i;
                shootPrev_q  <= shoot_i;
                if (!shoot_i) begin
                    shootArmed_q <= 1'b1;
                end
            end
        end
    end

    assign game_state_o = state_q;
    assign score_o      = score_q;
    assign lives_o      = lives_q;
    assign level_o      = level_q;
    assign move_o       = move_q;
    assign ship_en_o    = shipEn_q;
    assign wave_next_o  = waveNext_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl.
// The stimulus process drives directed vectors and queues expected snapshots and expected wave_next pulses.
// A separate monitor process compares them against the DUT on falling edges.
module tb_game_ctrl;

    typedef struct {
        string       tag;
        logic [1:0]  state;
        logic [7:0]  score;
        logic [1:0]  lives;
        logic [3:0]  level;
        logic        shipEn;
    } snapT;

    logic        clock = 1'b0;
    logic        reset;
    logic        pixpulse;
    logic        vblank;
    logic        shoot;
    logic [19:0] astHit;
    logic        shipHit;
    logic        allBroken;
    logic [1:0]  gameState;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic [3:0]  level;
    logic        move;
    logic        shipEn;
    logic        waveNext;

    snapT  expQ[$];
    string waveQ[$];
    int    checks       = 0;
    int    failures     = 0;
    int    moveCount    = 0;
    int    framesIssued = 0;

    game_ctrl #(
        .SCORE_W(8), .N_AST(20), .LIVES_INIT(3), .LIVES_W(2), .POINTS(1),
        .INVULN_FRAMES(120), .OVER_FRAMES(180), .LEVEL_W(4)
    ) dut (
        .clk_i        (clock),
        .rst_i        (reset),
        .pixpulse_i   (pixpulse),
        .vblank_i     (vblank),
        .shoot_i      (shoot),
        .ast_hit_i    (astHit),
        .ship_hit_i   (shipHit),
        .all_broken_i (allBroken),
        .game_state_o (gameState),
        .score_o      (score),
        .lives_o      (lives),
        .level_o      (level),
        .move_o       (move),
        .ship_en_o    (shipEn),
        .wave_next_o  (waveNext)
    );

    // 100 MHz clock.
    always #5 clock = ~clock;

    // Compare one observed value against its expected value and log any mismatch.
    task automatic checkOutput(input string tag, input string field, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%0d expected=%0d", tag, field, actual, expected);
        end
    endtask

    // Queue an expected snapshot for the monitor.
    task automatic expectState(input string tag, input int st, input int sc, input int lv, input int lev, input int en);
        snapT s;
        s.tag    = tag;
        s.state  = 2'(st);
        s.score  = 8'(sc);
        s.lives  = 2'(lv);
        s.level  = 4'(lev);
        s.shipEn = 1'(en);
        expQ.push_back(s);
    endtask

    // One pixel-enable period: pixpulse for one clock, then three idle clocks; pulse inputs last one clock.
    task automatic applyStimulus();
        pixpulse = 1'b1;
        @(posedge clock); #1;
        pixpulse  = 1'b0;
        astHit    = '0;
        shipHit   = 1'b0;
        allBroken = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
    endtask

    // One video frame: a vblank rise followed by a vblank fall.
    task automatic frameStep();
        vblank = 1'b1;
        applyStimulus();
        framesIssued++;
        vblank = 1'b0;
        applyStimulus();
    endtask

    task automatic runFrames(input int n);
        for (int i = 0; i < n; i++) frameStep();
    endtask

    task automatic hitStep(input logic [19:0] v);
        astHit = v;
        applyStimulus();
    endtask

    task automatic waveStep(input string tag);
        waveQ.push_back(tag);
        allBroken = 1'b1;
        applyStimulus();
    endtask

    // Monitor: drain queued snapshots and police move and wave_next pulses on every falling edge.
    initial begin
        snapT e;
        logic prevMove = 1'b0;
        logic prevWave = 1'b0;
        string wtag;
        forever begin
            @(negedge clock);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e.tag, "game_state", int'(gameState), int'(e.state));
                checkOutput(e.tag, "score", int'(score), int'(e.score));
                checkOutput(e.tag, "lives", int'(lives), int'(e.lives));
                checkOutput(e.tag, "level", int'(level), int'(e.level));
                checkOutput(e.tag, "ship_en", int'(shipEn), int'(e.shipEn));
                checkOutput(e.tag, "move", int'(move), 0);
            end
            if (waveNext && !prevWave) begin
                if (waveQ.size() == 0) begin
                    checkOutput("unexpected", "wave_next", 1, 0);
                end else begin
                    wtag = waveQ.pop_front();
                    checkOutput(wtag, "wave_next", 1, 1);
                end
            end
            if (waveNext && prevWave) checkOutput("wave_width", "wave_next_clocks", 2, 1);
            if (move && prevMove) checkOutput("move_width", "move_clocks", 2, 1);
            if (move) moveCount++;
            prevMove = move;
            prevWave = waveNext;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus sequence.
    initial begin
        reset = 1'b1; pixpulse = 1'b0; vblank = 1'b0; shoot = 1'b1;
        astHit = '0; shipHit = 1'b0; allBroken = 1'b0;
        repeat (2) applyStimulus();
        reset = 1'b0;
        expectState("reset", 0, 0, 3, 0, 0);

        repeat (3) applyStimulus();
        expectState("held_shoot_no_start", 0, 0, 3, 0, 0);
        shoot = 1'b0; applyStimulus();
        expectState("shoot_released", 0, 0, 3, 0, 0);
        shoot = 1'b1; applyStimulus();
        expectState("start", 1, 0, 3, 1, 1);
        shoot = 1'b0; applyStimulus();

        hitStep(20'h0000F); expectState("ast_x4", 1, 4, 3, 1, 1);
        hitStep(20'hFFFFF); expectState("ast_x20", 1, 24, 3, 1, 1);
        hitStep(20'h80001); expectState("ast_ends", 1, 26, 3, 1, 1);
        waveStep("wave_play"); expectState("level_up", 1, 26, 3, 2, 1);

        shipHit = 1'b1; applyStimulus();
        expectState("ship_hit_dying", 2, 26, 2, 2, 1);
        shipHit = 1'b1; applyStimulus();
        expectState("ship_hit_ignored", 2, 26, 2, 2, 1);
        astHit = 20'h00003; waveStep("wave_dying");
        expectState("dying_score_level", 2, 28, 2, 3, 1);

        for (int k = 1; k <= 120; k++) begin
            frameStep();
            if (k < 120) expectState("blink", 2, 28, 2, 3, ((120 - k) >> 3) & 1);
            else         expectState("dying_done", 1, 28, 2, 3, 1);
        end

        shipHit = 1'b1; waveStep("wave_with_hit");
        expectState("hit_and_wave", 2, 28, 1, 4, 1);
        runFrames(120);
        expectState("back_to_play", 1, 28, 1, 4, 1);

        shipHit = 1'b1; hitStep(20'h00001);
        expectState("last_life", 3, 29, 0, 4, 0);
        shoot = 1'b1; astHit = 20'h0000F; shipHit = 1'b1; allBroken = 1'b1;
        applyStimulus();
        shoot = 1'b0; applyStimulus();
        expectState("over_ignores", 3, 29, 0, 4, 0);
        runFrames(179);
        expectState("over_counting", 3, 29, 0, 4, 0);
        runFrames(1);
        expectState("over_done", 0, 29, 0, 4, 0);
        allBroken = 1'b1; applyStimulus();
        expectState("idle_no_wave", 0, 29, 0, 4, 0);

        shoot = 1'b1; applyStimulus();
        expectState("restart", 1, 0, 3, 1, 1);
        shoot = 1'b0;
        repeat (12) hitStep(20'hFFFFF);
        hitStep(20'h03FFF); expectState("score_254", 1, 254, 3, 1, 1);
        hitStep(20'h0000F); expectState("score_sat", 1, 255, 3, 1, 1);
        hitStep(20'h0000F); expectState("score_hold", 1, 255, 3, 1, 1);

        repeat (14) waveStep("wave_climb");
        expectState("level_15", 1, 255, 3, 15, 1);
        waveStep("wave_at_max");
        expectState("level_sat", 1, 255, 3, 15, 1);

        shipHit = 1'b1; applyStimulus();
        expectState("lose_1", 2, 255, 2, 15, 1);
        runFrames(120);
        shipHit = 1'b1; applyStimulus();
        expectState("lose_2", 2, 255, 1, 15, 1);
        runFrames(120);
        shipHit = 1'b1; applyStimulus();
        expectState("over_again", 3, 255, 0, 15, 0);
        runFrames(10);

        vblank = 1'b1; reset = 1'b1; pixpulse = 1'b1;
        @(posedge clock); #1;
        pixpulse = 1'b0; reset = 1'b0; vblank = 1'b0;
        expectState("reset_mid_over", 0, 0, 3, 0, 0);
        repeat (3) begin
            @(posedge clock); #1;
        end
        applyStimulus();
        expectState("after_reset", 0, 0, 3, 0, 0);

        repeat (2) begin
            @(posedge clock); #1;
        end
        checkOutput("end", "move_count", moveCount, framesIssued);
        checkOutput("end", "wave_pending", waveQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
